wb_stage: RTL and testbench

//  Writeback stage directly upstream of the register file: takes ALU results and load requests from execute,

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_stage_load_extend.sv | 55 +++++
 rtl/wb_stage.sv | 115 +++++++++++
 tb/tb_wb_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Writeback stage shared definitions: load funct3 codes, FSM states, error bits.
package wb_pkg;

    localparam logic [2:0] LOAD_LB  = 3'd0;
    localparam logic [2:0] LOAD_LH  = 3'd1;
    localparam logic [2:0] LOAD_LW  = 3'd2;
    localparam logic [2:0] LOAD_LBU = 3'd4;
    localparam logic [2:0] LOAD_LHU = 3'd5;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_STRAY    = 1;

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } wb_state_t;

endpackage

// File: rtl/wb_stage_load_extend.sv
// Load data alignment and sign/zero extension.
// Flags misaligned halfword/word loads and illegal funct3 codes.
module load_extend
    import wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] data,
    output logic        err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
    end

    // addr_lo[0] is ignored for halves, which is how misaligned halves are written
    assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        err  = 1'b0;
        case (funct3)
            LOAD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: data = {24'd0, byte_sel};
            LOAD_LH: begin
                data = {{16{half_sel[15]}}, half_sel};
                err  = addr_lo[0];
            end
            LOAD_LHU: begin
                data = {16'd0, half_sel};
                err  = addr_lo[0];
            end
            LOAD_LW: begin
                data = word;
                err  = (addr_lo != 2'b00);
            end
            default: begin
                data = word;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: ALU results and load completion to the register file write port.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [4:0]          ex_rd,
    input  logic                ex_rd_we,
    input  logic [XLEN-1:0]     ex_result,
    input  logic                ex_is_load,
    input  logic [2:0]          ex_funct3,
    input  logic [1:0]          ex_addr_lo,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_data,
    output logic [4:0]          write_reg,
    output logic [XLEN-1:0]     write_data,
    output logic                write_en,
    output logic                ld_pending,
    output logic [4:0]          ld_rd,
    output logic [1:0]          err_flags,
    output logic [RETIRE_W-1:0] retire_cnt
);

    wb_state_t       state;
    logic            lq_we;
    logic [2:0]      lq_f3;
    logic [1:0]      lq_addr;
    logic [XLEN-1:0] ext_data;
    logic            ext_err;

    assign ex_ready = (state == IDLE);

    load_extend u_ext (
        .funct3  (lq_f3),
        .addr_lo (lq_addr),
        .word    (mem_rsp_data),
        .data    (ext_data),
        .err     (ext_err)
    );

    // ld_rd doubles as the latched destination of the pending load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            write_en   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            ld_pending <= 1'b0;
            ld_rd      <= '0;
            err_flags  <= '0;
            lq_we      <= 1'b0;
            lq_f3      <= '0;
            lq_addr    <= '0;
        end else begin
            write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_rsp_valid)
                        err_flags[ERR_STRAY] <= 1'b1;
                    if (ex_valid) begin
                        if (ex_is_load) begin
                            state      <= WAIT_LOAD;
                            ld_pending <= 1'b1;
                            ld_rd      <= ex_rd;
                            lq_we      <= ex_rd_we;
                            lq_f3      <= ex_funct3;
                            lq_addr    <= ex_addr_lo;
                        end else if (ex_rd_we && ex_rd != 5'd0) begin
                            write_en   <= 1'b1;
                            write_reg  <= ex_rd;
                            write_data <= ex_result;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (mem_rsp_valid) begin
                        state      <= IDLE;
                        ld_pending <= 1'b0;
                        ld_rd      <= '0;
                        if (lq_we && ld_rd != 5'd0) begin
                            write_en   <= 1'b1;
                            write_reg  <= ld_rd;
                            write_data <= ext_data;
                        end
                        if (ext_err)
                            err_flags[ERR_MISALIGN] <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [RETIRE_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (write_en)
            cnt_q <= cnt_q + 1'b1;
    end

    assign retire_cnt = cnt_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed cases then random traffic against a reference model.
module tb_wb_stage;

`ifdef WB_RETIRE_CNT_EN
    localparam int RW = 4;
`else
    localparam int RW = 32;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_valid;
    logic          ex_ready;
    logic [4:0]    ex_rd;
    logic          ex_rd_we;
    logic [31:0]   ex_result;
    logic          ex_is_load;
    logic [2:0]    ex_funct3;
    logic [1:0]    ex_addr_lo;
    logic          mem_rsp_valid;
    logic [31:0]   mem_rsp_data;
    logic [4:0]    write_reg;
    logic [31:0]   write_data;
    logic          write_en;
    logic          ld_pending;
    logic [4:0]    ld_rd;
    logic [1:0]    err_flags;
    logic [RW-1:0] retire_cnt;

    int chk = 0;
    int errs = 0;

    // reference model state
    logic        m_pend;
    logic [4:0]  m_rd;
    logic        m_we;
    logic [2:0]  m_f3;
    logic [1:0]  m_addr;
    logic        m_wen;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    logic [1:0]  m_err;
    longint      m_retired;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .RETIRE_W(RW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_rd         (ex_rd),
        .ex_rd_we      (ex_rd_we),
        .ex_result     (ex_result),
        .ex_is_load    (ex_is_load),
        .ex_funct3     (ex_funct3),
        .ex_addr_lo    (ex_addr_lo),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .write_en      (write_en),
        .ld_pending    (ld_pending),
        .ld_rd         (ld_rd),
        .err_flags     (err_flags),
        .retire_cnt    (retire_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        chk++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [2:0] f3,
                                            input logic [1:0] a,
                                            input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 32'h80) ? b - 32'h100 : b;
            3'd4: return b;
            3'd1: return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd5: return h;
            default: return w;
        endcase
    endfunction

    function automatic logic ref_bad(input logic [2:0] f3, input logic [1:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && a % 2 == 1) return 1'b1;
        if (f3 == 3'd2 && a != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                         input logic [31:0] res, input logic ld,
                         input logic [2:0] f3, input logic [1:0] a,
                         input logic rsp, input logic [31:0] rdata);
        ex_valid      = v;
        ex_rd         = rd;
        ex_rd_we      = we;
        ex_result     = res;
        ex_is_load    = ld;
        ex_funct3     = f3;
        ex_addr_lo    = a;
        mem_rsp_valid = rsp;
        mem_rsp_data  = rdata;
    endtask

    // one clock: check ready, advance model, check registered outputs
    task automatic step(input string tag);
        logic nwen;
        #1;
        if (rst_n) check({tag, ".ready"}, {31'd0, ex_ready}, {31'd0, !m_pend});
        nwen = 1'b0;
        if (m_wen) m_retired++;
        if (!rst_n) begin
            m_pend = 0; m_rd = 0; m_we = 0; m_f3 = 0; m_addr = 0;
            m_wreg = 0; m_wdata = 0; m_err = 0; m_retired = 0;
        end else if (!m_pend) begin
            if (mem_rsp_valid) m_err[1] = 1'b1;
            if (ex_valid && ex_is_load) begin
                m_pend = 1; m_rd = ex_rd; m_we = ex_rd_we;
                m_f3 = ex_funct3; m_addr = ex_addr_lo;
            end else if (ex_valid && ex_rd_we && ex_rd != 0) begin
                nwen = 1; m_wreg = ex_rd; m_wdata = ex_result;
            end
        end else if (mem_rsp_valid) begin
            m_pend = 0;
            if (m_we && m_rd != 0) begin
                nwen = 1; m_wreg = m_rd;
                m_wdata = ref_ext(m_f3, m_addr, mem_rsp_data);
            end
            if (ref_bad(m_f3, m_addr)) m_err[0] = 1'b1;
            m_rd = 0;
        end
        m_wen = nwen;
        @(posedge clk);
        #1;
        check({tag, ".wen"}, {31'd0, write_en}, {31'd0, m_wen});
        check({tag, ".wreg"}, {27'd0, write_reg}, {27'd0, m_wreg});
        check({tag, ".wdata"}, write_data, m_wdata);
        check({tag, ".pend"}, {31'd0, ld_pending}, {31'd0, m_pend});
        check({tag, ".ldrd"}, {27'd0, ld_rd}, {27'd0, m_pend ? m_rd : 5'd0});
        check({tag, ".err"}, {30'd0, err_flags}, {30'd0, m_err});
`ifdef WB_RETIRE_CNT_EN
        check({tag, ".cnt"}, 32'(retire_cnt), 32'(m_retired % (64'd1 << RW)));
`else
        check({tag, ".cnt"}, 32'(retire_cnt), 32'd0);
`endif
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_wen = 0; m_retired = 0; m_pend = 0; m_rd = 0; m_err = 0;
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        step("reset");

        rst_n = 1'b1;
        drive(1, 5, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0); step("alu");
        drive(1, 0, 1, 32'h12345678, 0, 0, 0, 0, 0); step("x0");
        for (int i = 1; i <= 17; i++) begin
            drive(1, 5'(i), 1, 32'(i * 3), 0, 0, 0, 0, 0);
            step("b2b");
        end
        idle(); step("b2b_end");

        drive(1, 3, 1, 0, 1, 3'd0, 2'd3, 0, 0); step("lb_acc");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF1234); step("lb_rsp");
        drive(1, 4, 1, 0, 1, 3'd4, 2'd3, 0, 0); step("lbu_acc");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF1234); step("lbu_rsp");
        drive(1, 6, 1, 0, 1, 3'd1, 2'd2, 0, 0); step("lh_acc");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF1234); step("lh_rsp");

        drive(1, 7, 1, 0, 1, 3'd2, 2'd0, 0, 0); step("lw_acc");
        for (int i = 0; i < 3; i++) begin
            drive(1, 9, 1, 32'h55, 0, 0, 0, 0, 0); step("lw_wait");
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D); step("lw_rsp");
        idle(); step("lw_after");

        drive(1, 8, 1, 0, 1, 3'd2, 2'd1, 0, 0); step("mis_acc");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5_0F0F); step("mis_rsp");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h1); step("stray");

        rst_n = 1'b0; idle(); step("rst2");
        rst_n = 1'b1;
        drive(1, 10, 1, 0, 1, 3'd2, 2'd0, 0, 0); step("drop_acc");
        rst_n = 1'b0; idle(); step("drop_rst");
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h77); step("drop_rsp");

        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 99) >= 2);
            drive($urandom_range(0, 9) < 7, 5'($urandom), $urandom_range(0, 9) < 8,
                  $urandom, $urandom_range(0, 9) < 4, 3'($urandom),
                  2'($urandom), $urandom_range(0, 9) < 3, $urandom);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end

endmodule
